// File: rtl/mult_state_seq.sv
// Control sequencer for a 4-iteration add/shift multiplier: walks CLR, LOAD, INIT,
// then four ADD/SHIFT pairs, and parks in DONE until start is released.
module mult_state_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic [2:0] ps,
  output logic [1:0] cnt,
  output logic       busy,
  output logic       done
);

  // Encodings are fixed because the downstream decoder reads ps directly.
  typedef enum logic [2:0] {
    IDLE    = 3'b000,
    CLR     = 3'b001,
    LOAD    = 3'b010,
    INIT    = 3'b011,
    ADD     = 3'b100,
    SHIFT   = 3'b101,
    DONE    = 3'b110,
    ILLEGAL = 3'b111
  } state_t;

  logic [2:0] state_reg;
  state_t     state_next;
  logic [1:0] cnt_reg;
  logic [1:0] cnt_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= 2'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_t'(state_reg);
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (start) state_next = CLR;
      end
      CLR: begin
        state_next = LOAD;
        cnt_next   = 2'd0;
      end
      LOAD:  state_next = INIT;
      INIT:  state_next = ADD;
      ADD:   state_next = SHIFT;
      SHIFT: begin
        // cnt saturates at 3 on exit so it never wraps inside an operation.
        if (cnt_reg == 2'd3) begin
          state_next = DONE;
        end else begin
          state_next = ADD;
          cnt_next   = cnt_reg + 2'd1;
        end
      end
      DONE: begin
        if (!start) state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = 2'd0;
      end
    endcase
  end

  assign ps   = state_reg;
  assign cnt  = cnt_reg;
  assign busy = (state_reg != IDLE) && (state_reg != DONE) && (state_reg != ILLEGAL);
  assign done = (state_reg == DONE);

endmodule

// File: tb/tb_mult_state_seq.sv
// Directed scoreboard bench for mult_state_seq: each step queues the expected
// ps/cnt/busy/done and compares it against the DUT one edge later.
`timescale 1ns/1ps
module tb_mult_state_seq;

  logic       clk;
  logic       rst;
  logic       start;
  logic [2:0] ps;
  logic [1:0] cnt;
  logic       busy;
  logic       done;

  typedef struct packed {
    logic [2:0] ps;
    logic [1:0] cnt;
    logic       busy;
    logic       done;
  } obs_t;

  obs_t exp_q[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   step_no    = 0;

  mult_state_seq dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .ps    (ps),
    .cnt   (cnt),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic obs_t mk_exp(input logic [2:0] eps, input logic [1:0] ecnt);
    obs_t e;
    e.ps   = eps;
    e.cnt  = ecnt;
    e.busy = (eps == 3'd1) || (eps == 3'd2) || (eps == 3'd3) || (eps == 3'd4) || (eps == 3'd5);
    e.done = (eps == 3'd6);
    return e;
  endfunction

  task automatic check(input string tag, input obs_t got, input obs_t e);
    compared++;
    assert (got === e) else begin
      mismatched++;
      $error("FAIL %s step %0d: observed ps=%b cnt=%b busy=%b done=%b, expected ps=%b cnt=%b busy=%b done=%b",
             tag, step_no, got.ps, got.cnt, got.busy, got.done, e.ps, e.cnt, e.busy, e.done);
    end
  endtask

  task automatic cyc(input string tag, input logic s, input logic r,
                     input logic [2:0] eps, input logic [1:0] ecnt);
    obs_t got;
    obs_t e;
    @(negedge clk);
    start = s;
    rst   = r;
    exp_q.push_back(mk_exp(eps, ecnt));
    @(posedge clk);
    #1;
    step_no++;
    got = {ps, cnt, busy, done};
    e   = exp_q.pop_front();
    check(tag, got, e);
    $display("step %0d %s start=%b rst=%b -> ps=%b cnt=%b busy=%b done=%b",
             step_no, tag, s, r, ps, cnt, busy, done);
  endtask

  // mode 0: start low after launch; 1: held high; 2: toggles on edges 2..10.
  function automatic logic start_for(input int mode, input int k);
    if (mode == 1) return 1'b1;
    if (mode == 2 && k <= 10) return k[0];
    return 1'b0;
  endfunction

  task automatic full_run(input string tag, input logic [1:0] cnt0, input int mode);
    int k;
    cyc(tag, 1'b1, 1'b0, 3'd1, cnt0);
    k = 2;
    cyc(tag, start_for(mode, k), 1'b0, 3'd2, 2'd0); k++;
    cyc(tag, start_for(mode, k), 1'b0, 3'd3, 2'd0); k++;
    for (int i = 0; i < 4; i++) begin
      cyc(tag, start_for(mode, k), 1'b0, 3'd4, 2'(i)); k++;
      cyc(tag, start_for(mode, k), 1'b0, 3'd5, 2'(i)); k++;
    end
    cyc(tag, start_for(mode, k), 1'b0, 3'd6, 2'd3);
  endtask

  initial begin
    obs_t got;
    rst   = 1'b1;
    start = 1'b0;

    cyc("reset", 1'b0, 1'b1, 3'd0, 2'd0);
    cyc("reset", 1'b0, 1'b1, 3'd0, 2'd0);
    cyc("idle", 1'b0, 1'b0, 3'd0, 2'd0);

    full_run("nominal", 2'd0, 0);
    cyc("done_exit", 1'b0, 1'b0, 3'd0, 2'd3);
    cyc("idle_hold", 1'b0, 1'b0, 3'd0, 2'd3);

    full_run("held", 2'd3, 1);
    for (int i = 0; i < 5; i++) cyc("held_done", 1'b1, 1'b0, 3'd6, 2'd3);
    cyc("held_exit", 1'b0, 1'b0, 3'd0, 2'd3);
    cyc("no_retrig", 1'b0, 1'b0, 3'd0, 2'd3);

    full_run("toggle", 2'd3, 2);
    cyc("toggle_exit", 1'b0, 1'b0, 3'd0, 2'd3);

    cyc("rst_mid", 1'b1, 1'b0, 3'd1, 2'd3);
    cyc("rst_mid", 1'b0, 1'b0, 3'd2, 2'd0);
    cyc("rst_mid", 1'b0, 1'b0, 3'd3, 2'd0);
    cyc("rst_mid", 1'b0, 1'b0, 3'd4, 2'd0);
    cyc("rst_mid", 1'b0, 1'b0, 3'd5, 2'd0);
    cyc("rst_mid", 1'b0, 1'b0, 3'd4, 2'd1);
    cyc("rst_mid", 1'b0, 1'b0, 3'd5, 2'd1);
    cyc("rst_hit", 1'b0, 1'b1, 3'd0, 2'd0);
    for (int i = 0; i < 3; i++) cyc("rst_after", 1'b0, 1'b0, 3'd0, 2'd0);
    cyc("rst_hold", 1'b1, 1'b1, 3'd0, 2'd0);
    cyc("rst_hold", 1'b1, 1'b1, 3'd0, 2'd0);
    cyc("rst_rel", 1'b0, 1'b0, 3'd0, 2'd0);

    full_run("b2b_a", 2'd0, 0);
    cyc("b2b_stay", 1'b1, 1'b0, 3'd6, 2'd3);
    cyc("b2b_idle", 1'b0, 1'b0, 3'd0, 2'd3);
    full_run("b2b_b", 2'd3, 0);
    cyc("b2b_exit", 1'b0, 1'b0, 3'd0, 2'd3);

    @(negedge clk);
    start = 1'b0;
    rst   = 1'b0;
    force dut.state_reg = 3'b111;
    #1;
    release dut.state_reg;
    #1;
    got = {ps, cnt, busy, done};
    step_no++;
    check("illegal_in", got, mk_exp(3'b111, 2'd3));
    $display("step %0d illegal_in -> ps=%b cnt=%b busy=%b done=%b", step_no, ps, cnt, busy, done);
    cyc("illegal_out", 1'b0, 1'b0, 3'd0, 2'd0);
    cyc("illegal_idle", 1'b0, 1'b0, 3'd0, 2'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
